cordic_step_seq: RTL and testbench
==================================

Name: cordic_step_seq

Overview:
- Per-iteration step generator for the generalised CORDIC rotation core. One accepted start produces a sequence of ITER micro-rotation steps.
- Each step carries an iteration index, a shift amount and an angle/step constant Dz. Linear, circular and hyperbolic modes are supported.
- Hyperbolic mode inserts the repeated iterations at shifts 4, 13 and 40.
- Sits between the rotation controller and the datapath. Steps are delivered over a valid/ready handshake so the datapath can stall.

Parameters:
- DSIZE, 16, Dz width. Unsigned fixed point; 2^(DSIZE-1) represents 1.0. Legal range 8..32.
- ITER, 16, steps emitted per sequence, repeats included. Legal range 1..32.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sequence. Sampled only in IDLE.
- mode  in  2  0 linear, 1 circular, 2 hyperbolic, 3 reserved. Latched when start is accepted.
- busy  out  1  high in RUN and DONE.
- mode_err  out  1  one-cycle pulse when start is sampled in IDLE with mode=3.
- step_valid  out  1  step fields valid.
- step_ready  in  1  consumer accepts the step.
- step_idx  out  5  step count within the sequence, 0..ITER-1.
- step_shift  out  5  shift amount i for this step.
- step_dz  out  DSIZE  angle constant for step_shift in the latched mode.
- step_last  out  1  marks step_idx==ITER-1.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0.
  - Internal count and shift registers are cleared; next_rep is set to 4.
  - Reset mid-sequence abandons the sequence. No done pulse is produced.
- Clocking: all outputs are registered. No combinational path from step_ready to any output.
- State IDLE:
  - start=1 with mode in 0..2 goes to RUN and latches the mode.
  - On that transition: step_idx=0; step_shift=0 for linear/circular or 1 for hyperbolic; next_rep=4; rep_done=0; step_valid=1 from the next cycle (latency 1).
  - start=1 with mode=3: stay in IDLE and pulse mode_err.
- State RUN:
  - step_valid=1. All step fields are held stable while step_ready=0.
  - Handshake = step_valid and step_ready in the same cycle.
  - On a handshake with step_idx==ITER-1: go to DONE and drop step_valid.
  - On any other handshake, step_idx increments and step_shift advances as follows:
    - Linear/circular: shift+1.
    - Hyperbolic, shift==next_rep and rep_done=0: shift unchanged, rep_done=1.
    - Hyperbolic, otherwise: shift+1 and rep_done=0. If shift==next_rep, then next_rep=3*next_rep+1.
  - step_shift saturates at 31.
- State DONE: done=1 for exactly one cycle, then return to IDLE. start is ignored in DONE.
- start while busy is ignored; there is no queueing.
- Dz values:
  - Linear: 2^(DSIZE-1) >> shift. A result of 0 is allowed once shift > DSIZE-1.
  - Circular: round(atan(2^-shift) * 2^(DSIZE-1)).
  - Hyperbolic: round(atanh(2^-shift) * 2^(DSIZE-1)), shift >= 1.
  - Rounding is half-up.
  - Dz is computed from the package 32-bit tables, which are scaled by 2^31, so no table entry overflows DSIZE bits.
- Dz is looked up from the next shift and registered together with it, so step_dz always matches step_shift.

Decomposition:
- cordic_pkg contains:
  - mode encodings MODE_LIN, MODE_CIR, MODE_HYP, MODE_RSV;
  - ATAN_TAB[0:31] and ATANH_TAB[1:31] as 32-bit constants scaled 2^31;
  - function scale_dz(val32, DSIZE), doing a rounded right-shift by 32-DSIZE.
- Sub-module cordic_angle_lut: combinational (mode, shift) -> Dz. It is the multi-mode generalisation of the linear table. The sequencer FSM instantiates it and registers its output.

Test Plan:
- Linear, DSIZE=16, ITER=16, step_ready=1:
  - Steps arrive on consecutive cycles starting one cycle after start.
  - shift 0..15; Dz 0x8000, 0x4000, ... 0x0001.
  - step_last on idx 15; done one cycle later; busy low after done.
- Circular, DSIZE=16: shift0 Dz=25736 (0x6488), shift1 Dz=15193; step_idx equals step_shift throughout.
- Hyperbolic, DSIZE=16, ITER=6:
  - shifts 1,2,3,4,4,5; Dz at shift1=18000; Dz at shift4=2051 on both steps.
  - ITER=16 additionally shows shift 13 repeated.
- Backpressure: hold step_ready=0 for 5 cycles mid-sequence -> all step fields stable and no step lost or duplicated. start pulsed while busy -> ignored.
- Boundaries:
  - mode=3 start -> mode_err pulse, busy stays 0, no step_valid.
  - ITER=1 -> single step with step_last=1, then done.
  - DSIZE=8 linear shift 8 -> Dz=0.
- Reset: assert rst_n=0 mid-RUN with step_ready=0 -> all outputs 0 immediately. After release, a new start begins from step_idx=0.

Source files
------------

// File: rtl/cordic_step_seq_pkg.sv
// Shared definitions for the CORDIC step sequencer: mode/state encodings,
// field widths, arctan/artanh constant tables and the Dz scaling helper.
package cordic_pkg;

    localparam int MODE_W  = 2;
    localparam int IDX_W   = 5;
    localparam int SHIFT_W = 5;
    localparam int REP_W   = 8;

    // First hyperbolic shift that must be executed twice; later ones follow 3k+1.
    localparam logic [REP_W-1:0]   REP_FIRST = 8'd4;
    localparam logic [SHIFT_W-1:0] SHIFT_MAX = 5'd31;

    typedef enum logic [MODE_W-1:0] {
        MODE_LIN = 2'd0,
        MODE_CIR = 2'd1,
        MODE_HYP = 2'd2,
        MODE_RSV = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // round(atan(2^-i) * 2^31)
    localparam logic [31:0] ATAN_TAB [0:31] = '{
        32'd1686629713, 32'd995675659, 32'd526087673, 32'd267050317,
        32'd134043374,  32'd67087031,  32'd33551702,  32'd16776875,
        32'd8388565,    32'd4194299,   32'd2097151,   32'd1048576,
        32'd524288,     32'd262144,    32'd131072,    32'd65536,
        32'd32768,      32'd16384,     32'd8192,      32'd4096,
        32'd2048,       32'd1024,      32'd512,       32'd256,
        32'd128,        32'd64,        32'd32,        32'd16,
        32'd8,          32'd4,         32'd2,         32'd1
    };

    // round(atanh(2^-i) * 2^31); atanh(1) is infinite so the table starts at 1.
    localparam logic [31:0] ATANH_TAB [1:31] = '{
                        32'd1179625963, 32'd548494837, 32'd269846813,
        32'd134392901,  32'd67130722,  32'd33557163,  32'd16777557,
        32'd8388651,    32'd4194309,   32'd2097153,   32'd1048576,
        32'd524288,     32'd262144,    32'd131072,    32'd65536,
        32'd32768,      32'd16384,     32'd8192,      32'd4096,
        32'd2048,       32'd1024,      32'd512,       32'd256,
        32'd128,        32'd64,        32'd32,        32'd16,
        32'd8,          32'd4,         32'd2,         32'd1
    };

    // Rescale a 2^31-scaled constant to 2^(dsize-1), rounding half-up.
    // Table entries are below 2^31, so the 33-bit sum cannot overflow.
    function automatic logic [31:0] scale_dz(input logic [31:0] val32, input int dsize);
        logic [32:0] sum;
        if (dsize >= 32) begin
            return val32;
        end
        sum = {1'b0, val32} + (33'd1 << (31 - dsize));
        return 32'(sum >> (32 - dsize));
    endfunction

endpackage

// File: rtl/cordic_step_seq_if.sv
// Step handshake bundle between rotation controller, sequencer and datapath.
interface cordic_step_seq_if #(parameter int DSIZE = 16) ();
    import cordic_pkg::*;

    logic                start;
    logic [MODE_W-1:0]   mode;
    logic                busy;
    logic                mode_err;
    logic                step_valid;
    logic                step_ready;
    logic [IDX_W-1:0]    step_idx;
    logic [SHIFT_W-1:0]  step_shift;
    logic [DSIZE-1:0]    step_dz;
    logic                step_last;
    logic                done;

    // Sequencer side.
    modport master (
        input  start, mode, step_ready,
        output busy, mode_err, step_valid, step_idx, step_shift, step_dz,
               step_last, done
    );

    // Controller/datapath side.
    modport slave (
        output start, mode, step_ready,
        input  busy, mode_err, step_valid, step_idx, step_shift, step_dz,
               step_last, done
    );
endinterface

// File: rtl/cordic_step_seq_angle_lut.sv
// Combinational (mode, shift) -> Dz constant lookup for all three CORDIC modes.
module cordic_angle_lut
    import cordic_pkg::*;
#(
    parameter int DSIZE = 16
) (
    input  mode_t               mode,
    input  logic [SHIFT_W-1:0]  shift,
    output logic [DSIZE-1:0]    dz
);

    localparam logic [31:0] LIN_ONE = 32'h1 << (DSIZE - 1);

    logic [DSIZE-1:0] lin_tab [32];
    logic [DSIZE-1:0] cir_tab [32];
    logic [DSIZE-1:0] hyp_tab [32];

    // Per-shift constants, already scaled to DSIZE; linear truncates to 0 past DSIZE-1.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_tab
            assign lin_tab[gi] = DSIZE'(LIN_ONE >> gi);
            assign cir_tab[gi] = DSIZE'(scale_dz(ATAN_TAB[gi], DSIZE));
            if (gi == 0) begin : g_hyp0
                // Hyperbolic never uses shift 0.
                assign hyp_tab[gi] = '0;
            end else begin : g_hyp
                assign hyp_tab[gi] = DSIZE'(scale_dz(ATANH_TAB[gi], DSIZE));
            end
        end
    endgenerate

    // Select the table for the requested mode.
    always_comb begin
        dz = '0;
        case (mode)
            MODE_LIN: dz = lin_tab[shift];
            MODE_CIR: dz = cir_tab[shift];
            MODE_HYP: dz = hyp_tab[shift];
            default:  dz = '0;
        endcase
    end

endmodule

// File: rtl/cordic_step_seq.sv
// CORDIC step sequencer: one accepted start emits ITER (idx, shift, Dz) steps
// over a valid/ready handshake, with hyperbolic repeats at shifts 4, 13, 40.
module cordic_step_seq #(
    parameter int DSIZE = 16,
    parameter int ITER  = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    cordic_step_seq_if.master bus
);
    import cordic_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITER - 1);

    seq_state_t          state_reg,    state_next;
    mode_t               mode_reg,     mode_next;
    logic [IDX_W-1:0]    idx_reg,      idx_next;
    logic [SHIFT_W-1:0]  shift_reg,    shift_next;
    logic [DSIZE-1:0]    dz_reg,       dz_next;
    logic                rep_done_reg, rep_done_next;
    logic [REP_W-1:0]    next_rep_reg, next_rep_next;
    logic                valid_reg,    valid_next;
    logic                last_reg,     last_next;
    logic                busy_reg,     busy_next;
    logic                done_reg,     done_next;
    logic                mode_err_reg, mode_err_next;
    logic                step_load;
    logic                at_rep;
    logic [DSIZE-1:0]    lut_dz;
    mode_t               req_mode;

    assign req_mode = mode_t'(bus.mode);
    assign at_rep   = ({{(REP_W-SHIFT_W){1'b0}}, shift_reg} == next_rep_reg);

    // Dz is looked up from the shift/mode being loaded so it lands with that shift.
    cordic_angle_lut #(.DSIZE(DSIZE)) u_lut (
        .mode  (mode_next),
        .shift (shift_next),
        .dz    (lut_dz)
    );

    assign dz_next = step_load ? lut_dz : dz_reg;

    // State and registered outputs; reset abandons any sequence in flight.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= MODE_LIN;
            idx_reg      <= '0;
            shift_reg    <= '0;
            dz_reg       <= '0;
            rep_done_reg <= 1'b0;
            next_rep_reg <= REP_FIRST;
            valid_reg    <= 1'b0;
            last_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            mode_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            idx_reg      <= idx_next;
            shift_reg    <= shift_next;
            dz_reg       <= dz_next;
            rep_done_reg <= rep_done_next;
            next_rep_reg <= next_rep_next;
            valid_reg    <= valid_next;
            last_reg     <= last_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            mode_err_reg <= mode_err_next;
        end
    end

    // Next-state and next-output logic; everything holds unless a start or handshake occurs.
    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        idx_next      = idx_reg;
        shift_next    = shift_reg;
        rep_done_next = rep_done_reg;
        next_rep_next = next_rep_reg;
        valid_next    = valid_reg;
        last_next     = last_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        mode_err_next = 1'b0;
        step_load     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    if (req_mode == MODE_RSV) begin
                        mode_err_next = 1'b1;
                    end else begin
                        state_next    = ST_RUN;
                        mode_next     = req_mode;
                        idx_next      = '0;
                        shift_next    = (req_mode == MODE_HYP) ? 5'd1 : 5'd0;
                        next_rep_next = REP_FIRST;
                        rep_done_next = 1'b0;
                        valid_next    = 1'b1;
                        last_next     = (LAST_IDX == '0);
                        busy_next     = 1'b1;
                        step_load     = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (valid_reg && bus.step_ready) begin
                    if (last_reg) begin
                        state_next = ST_DONE;
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next  = idx_reg + 5'd1;
                        last_next = (idx_next == LAST_IDX);
                        step_load = 1'b1;
                        if (mode_reg == MODE_HYP && at_rep && !rep_done_reg) begin
                            // Repeat this shift once for hyperbolic convergence.
                            rep_done_next = 1'b1;
                        end else begin
                            shift_next    = (shift_reg == SHIFT_MAX) ? SHIFT_MAX : shift_reg + 5'd1;
                            rep_done_next = 1'b0;
                            if (mode_reg == MODE_HYP && at_rep) begin
                                next_rep_next = next_rep_reg * 8'd3 + 8'd1;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign bus.busy       = busy_reg;
    assign bus.mode_err   = mode_err_reg;
    assign bus.step_valid = valid_reg;
    assign bus.step_idx   = idx_reg;
    assign bus.step_shift = shift_reg;
    assign bus.step_dz    = dz_reg;
    assign bus.step_last  = last_reg;
    assign bus.done       = done_reg;

endmodule

// File: tb/tb_cordic_step_seq.sv
// Directed bench for cordic_step_seq: four instances cover the DSIZE/ITER corners.
module tb_cordic_step_seq;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    cordic_step_seq_if #(.DSIZE(16)) if16 ();
    cordic_step_seq_if #(.DSIZE(16)) if6  ();
    cordic_step_seq_if #(.DSIZE(16)) if1  ();
    cordic_step_seq_if #(.DSIZE(8))  if8  ();

    cordic_step_seq #(.DSIZE(16), .ITER(16)) u16 (.clock(clock), .rst_n(rst_n), .bus(if16));
    cordic_step_seq #(.DSIZE(16), .ITER(6))  u6  (.clock(clock), .rst_n(rst_n), .bus(if6));
    cordic_step_seq #(.DSIZE(16), .ITER(1))  u1  (.clock(clock), .rst_n(rst_n), .bus(if1));
    cordic_step_seq #(.DSIZE(8),  .ITER(16)) u8  (.clock(clock), .rst_n(rst_n), .bus(if8));

    // Hand-computed hyperbolic sequence for DSIZE=16 (repeats at 4 and 13).
    logic [4:0]  hyp_sh [16] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd5, 5'd6, 5'd7,
                                 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd13, 5'd14};
    logic [15:0] hyp_dz [16] = '{16'd18000, 16'd8369, 16'd4118, 16'd2051, 16'd2051,
                                 16'd1024, 16'd512, 16'd256, 16'd128, 16'd64, 16'd32,
                                 16'd16, 16'd8, 16'd4, 16'd4, 16'd2};
    logic [15:0] cir_dz [3]  = '{16'd25736, 16'd15193, 16'd8027};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step16(input string tag, input int idx, input int sh, input int dz, input bit last);
        chk($sformatf("%s valid%0d", tag, idx), 32'(if16.step_valid), 32'd1);
        chk($sformatf("%s idx%0d", tag, idx), 32'(if16.step_idx), 32'(idx));
        chk($sformatf("%s shift%0d", tag, idx), 32'(if16.step_shift), 32'(sh));
        chk($sformatf("%s dz%0d", tag, idx), 32'(if16.step_dz), 32'(dz));
        chk($sformatf("%s last%0d", tag, idx), 32'(if16.step_last), 32'(last));
    endtask

    task automatic end16(input string tag);
        @(negedge clock);
        chk({tag, " done"}, 32'(if16.done), 32'd1);
        chk({tag, " valid off"}, 32'(if16.step_valid), 32'd0);
        chk({tag, " busy in done"}, 32'(if16.busy), 32'd1);
        @(negedge clock);
        chk({tag, " done off"}, 32'(if16.done), 32'd0);
        chk({tag, " busy off"}, 32'(if16.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        if16.start = 1'b0; if16.mode = 2'd0; if16.step_ready = 1'b0;
        if6.start  = 1'b0; if6.mode  = 2'd0; if6.step_ready  = 1'b0;
        if1.start  = 1'b0; if1.mode  = 2'd0; if1.step_ready  = 1'b0;
        if8.start  = 1'b0; if8.mode  = 2'd0; if8.step_ready  = 1'b0;

        // Reset state
        @(negedge clock);
        chk("reset outs", 32'({if16.busy, if16.mode_err, if16.step_valid, if16.step_idx,
                               if16.step_shift, if16.step_dz, if16.step_last, if16.done}), 32'd0);
        rst_n = 1'b1;
        @(negedge clock);
        chk("idle busy", 32'(if16.busy), 32'd0);

        // Linear, full throughput
        if16.mode = 2'd0; if16.start = 1'b1; if16.step_ready = 1'b1;
        @(negedge clock);
        if16.start = 1'b0;
        chk("lin busy", 32'(if16.busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clock);
            step16("lin", i, i, 32'h8000 >> i, i == 15);
        end
        end16("lin");

        // Circular
        if16.mode = 2'd1; if16.start = 1'b1;
        @(negedge clock);
        if16.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clock);
            chk($sformatf("cir idx%0d", i), 32'(if16.step_idx), 32'(i));
            chk($sformatf("cir shift%0d", i), 32'(if16.step_shift), 32'(i));
            if (i < 3) chk($sformatf("cir dz%0d", i), 32'(if16.step_dz), 32'(cir_dz[i]));
        end
        end16("cir");

        // Hyperbolic, ITER=16 and ITER=6 side by side
        if16.mode = 2'd2; if16.start = 1'b1;
        if6.mode  = 2'd2; if6.start  = 1'b1; if6.step_ready = 1'b1;
        @(negedge clock);
        if16.start = 1'b0; if6.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clock);
            step16("hyp16", i, 32'(hyp_sh[i]), 32'(hyp_dz[i]), i == 15);
            if (i < 6) begin
                chk($sformatf("hyp6 idx%0d", i), 32'(if6.step_idx), 32'(i));
                chk($sformatf("hyp6 shift%0d", i), 32'(if6.step_shift), 32'(hyp_sh[i]));
                chk($sformatf("hyp6 dz%0d", i), 32'(if6.step_dz), 32'(hyp_dz[i]));
                chk($sformatf("hyp6 last%0d", i), 32'(if6.step_last), 32'(i == 5));
            end
            if (i == 6) begin
                chk("hyp6 done", 32'(if6.done), 32'd1);
                chk("hyp6 valid off", 32'(if6.step_valid), 32'd0);
            end
        end
        end16("hyp16");

        // Backpressure: 5-cycle stall at idx 3 with an ignored start
        if16.mode = 2'd0; if16.start = 1'b1;
        @(negedge clock);
        if16.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clock);
            step16("bp", i, i, 32'h8000 >> i, i == 15);
            if (i == 3) begin
                if16.step_ready = 1'b0; if16.start = 1'b1; if16.mode = 2'd2;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clock);
                    if16.start = 1'b0;
                    step16($sformatf("bp hold%0d", k), 3, 3, 16'h1000, 1'b0);
                    chk($sformatf("bp busy%0d", k), 32'(if16.busy), 32'd1);
                end
                if16.step_ready = 1'b1;
            end
        end
        end16("bp");
        @(negedge clock);
        chk("bp no restart", 32'(if16.step_valid), 32'd0);

        // Reserved mode
        if16.mode = 2'd3; if16.start = 1'b1;
        @(negedge clock);
        if16.start = 1'b0;
        chk("rsv mode_err", 32'(if16.mode_err), 32'd1);
        chk("rsv busy", 32'(if16.busy), 32'd0);
        chk("rsv valid", 32'(if16.step_valid), 32'd0);
        @(negedge clock);
        chk("rsv mode_err off", 32'(if16.mode_err), 32'd0);
        chk("rsv still idle", 32'({if16.busy, if16.step_valid}), 32'd0);

        // ITER=1 and DSIZE=8 linear side by side
        if1.mode = 2'd0; if1.start = 1'b1; if1.step_ready = 1'b1;
        if8.mode = 2'd0; if8.start = 1'b1; if8.step_ready = 1'b1;
        @(negedge clock);
        if1.start = 1'b0; if8.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clock);
            chk($sformatf("d8 idx%0d", i), 32'(if8.step_idx), 32'(i));
            chk($sformatf("d8 dz%0d", i), 32'(if8.step_dz), 32'h80 >> i);
            if (i == 0) begin
                chk("it1 valid", 32'(if1.step_valid), 32'd1);
                chk("it1 fields", 32'({if1.step_idx, if1.step_shift, if1.step_last}), 32'd1);
                chk("it1 dz", 32'(if1.step_dz), 32'h8000);
            end
            if (i == 1) chk("it1 done", 32'({if1.done, if1.step_valid}), 32'b10);
            if (i == 2) chk("it1 idle", 32'({if1.done, if1.busy}), 32'd0);
        end

        // Asynchronous reset mid-sequence, then a clean restart
        if16.mode = 2'd0; if16.step_ready = 1'b0; if16.start = 1'b1;
        @(negedge clock);
        if16.start = 1'b0;
        @(negedge clock);
        step16("pre-rst", 0, 0, 16'h8000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst async outs", 32'({if16.busy, if16.mode_err, if16.step_valid, if16.step_idx,
                                   if16.step_shift, if16.step_dz, if16.step_last, if16.done}), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        chk("post-rst idle", 32'({if16.done, if16.busy, if16.step_valid}), 32'd0);
        if16.step_ready = 1'b1; if16.start = 1'b1;
        @(negedge clock);
        if16.start = 1'b0;
        step16("restart", 0, 0, 16'h8000, 1'b0);
        repeat (17) @(negedge clock);
        chk("restart finished", 32'({if16.busy, if16.done}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
